writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//   Final pipeline stage; the producer side of the register-file write port consumed by decode.
//   Accepts retiring instructions from the MEM stage over a valid/ready handshake.
//   Waits for multi-cycle load data when needed, then drives writedata/writeregsel/RegWrite.
//   Every instruction produces exactly one commit cycle, carrying JAL link, ALU result or load data.
// PARAMETERS
//   DATA_W        32  datapath width
//   CNT_W         16  width of retired-instruction counter
//   LOAD_TIMEOUT  15  max cycles in WAIT_LOAD before abandoning the load (>=1)
// PORTS
//   clk              in   1       clock, all state on rising edge
//   rst              in   1       synchronous reset, active-high
//   in_valid         in   1       MEM stage presents an instruction
//   in_ready         out  1       stage can accept this cycle
//   in_result        in   DATA_W  ALU result
//   in_pc_plus_8     in   DATA_W  link value for JAL
//   in_regsel        in   5       destination register (already muxed: rd/rt/r8/r31)
//   in_reg_write     in   1       instruction writes a register
//   in_mem_to_reg    in   1       destination data comes from memory (load)
//   in_is_jal        in   1       destination data is in_pc_plus_8
//   mem_rdata        in   DATA_W  load data from data memory
//   mem_rdata_valid  in   1       mem_rdata valid this cycle
//   writedata        out  DATA_W  register-file write data (to decode)
//   writeregsel      out  5       register-file write select (to decode)
//   RegWrite         out  1       register-file write enable (to decode)
//   busy             out  1       high in WAIT_LOAD
//   retired_count    out  CNT_W   instructions committed since reset
//   err              out  1       sticky: a load timed out
// BEHAVIOUR
//   Reset: state=IDLE; writedata=0, writeregsel=0, RegWrite=0, retired_count=0, err=0.
//   States: IDLE, WAIT_LOAD, COMMIT (state register; RegWrite decoded from it, glitch-free).
//   in_ready = (state != WAIT_LOAD). Transfer = in_valid & in_ready.
//   Data select at transfer:
//     in_is_jal -> pc_plus_8
//     else in_mem_to_reg & in_reg_write -> load
//     else -> in_result
//   JAL has priority over mem_to_reg.
//   IDLE/COMMIT + transfer:
//     - load -> WAIT_LOAD; latch regsel/reg_write; clear timeout counter.
//     - non-load -> COMMIT; latch data.
//   IDLE/COMMIT, no transfer: COMMIT -> IDLE, IDLE stays.
//   WAIT_LOAD: mem_rdata_valid sampled from the cycle after acceptance on.
//     - On valid: latch mem_rdata -> COMMIT.
//     - Valid in the acceptance cycle is ignored; valid in IDLE/COMMIT is ignored.
//   Timeout: counter increments each WAIT_LOAD cycle without valid.
//     - On reaching LOAD_TIMEOUT: -> IDLE; no commit; retired_count unchanged; err<=1 until rst.
//   COMMIT (exactly one cycle per instruction):
//     - writedata, writeregsel = latched values.
//     - RegWrite = latched reg_write & (regsel != 0); register 0 writes are suppressed.
//     - retired_count += 1, wraps modulo 2^CNT_W, counted even when RegWrite=0.
//   Outside COMMIT: RegWrite=0; writedata/writeregsel hold last committed values (decode forwards on match).
//   Latency:
//     - non-load accepted in cycle N -> RegWrite in cycle N+1.
//     - load data valid in cycle M -> RegWrite in cycle M+1.
//   Throughput: back-to-back non-loads commit every cycle; COMMIT->COMMIT is legal.
//   rst in any state overrides everything; rst during WAIT_LOAD discards the pending load.
//     - No write occurs in the reset cycle or after it.
// TESTING
//   1. ALU op: regsel=5, result=0x1234, valid 1 cycle -> next cycle RegWrite=1, writeregsel=5, writedata=0x1234; count=1.
//   2. JAL with mem_to_reg=1, pc_plus_8=0x40, regsel=31 -> one cycle later write r31=0x40; no WAIT_LOAD.
//   3. Load regsel=9, rdata_valid 3 cycles later with 0xBEEF -> in_ready=0 and busy=1 in between, then write r9=0xBEEF.
//   4. Load with no rdata_valid -> after 15 cycles IDLE, err=1, no RegWrite, count unchanged.
//      A following ALU op still commits.
//   5. regsel=0, reg_write=1 -> COMMIT cycle with RegWrite=0; count increments.
//   6. 4 back-to-back ALU ops -> RegWrite high 4 consecutive cycles, in order.
//      rst asserted during a pending load -> outputs 0 next cycle, no write.

Source files
------------

// File: rtl/writeback_stage_if.sv
// MEM -> writeback retirement bus: one instruction per valid/ready transfer.
// The master is the MEM stage, and the slave is the writeback stage.
interface writeback_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_pc_plus_8;
  logic [4:0]        in_regsel;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic              in_is_jal;

  modport master (
    output in_valid, in_result, in_pc_plus_8, in_regsel,
           in_reg_write, in_mem_to_reg, in_is_jal,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_result, in_pc_plus_8, in_regsel,
           in_reg_write, in_mem_to_reg, in_is_jal,
    output in_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires instructions into the register-file write port,
// waiting (with timeout) for load data when the destination comes from memory.
module writeback_stage #(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 16,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  writeback_stage_if.slave    in_if,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rdata_valid,
  output logic [DATA_W-1:0]   writedata,
  output logic [4:0]          writeregsel,
  output logic                RegWrite,
  output logic                busy,
  output logic [CNT_W-1:0]    retired_count,
  output logic                err
);

  localparam int TMO_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    COMMIT    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [4:0]         pend_sel_q, pend_sel_d;
  logic               pend_we_q, pend_we_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  writedata_q, writedata_d;
  logic [4:0]         writeregsel_q, writeregsel_d;
  logic               reg_write_q, reg_write_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic               xfer_s;
  logic               is_load_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [TMO_W-1:0]   tmo_inc_s;
  logic [DATA_W-1:0]  commit_data_s;
  logic [4:0]         commit_sel_s;
  logic               commit_we_s;

  assign in_if.in_ready = (state_q != WAIT_LOAD);
  assign xfer_s         = in_if.in_valid & in_if.in_ready;
  assign is_load_s      = ~in_if.in_is_jal & in_if.in_mem_to_reg & in_if.in_reg_write;
  assign sel_data_s     = in_if.in_is_jal ? in_if.in_pc_plus_8 : in_if.in_result;
  assign tmo_inc_s      = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};

  // State register and all datapath flops; reset drops any pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tmo_q         <= '0;
      pend_sel_q    <= 5'd0;
      pend_we_q     <= 1'b0;
      err_q         <= 1'b0;
      writedata_q   <= '0;
      writeregsel_q <= 5'd0;
      reg_write_q   <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      pend_sel_q    <= pend_sel_d;
      pend_we_q     <= pend_we_d;
      err_q         <= err_d;
      writedata_q   <= writedata_d;
      writeregsel_q <= writeregsel_d;
      reg_write_q   <= reg_write_d;
      retired_q     <= retired_d;
    end
  end

  // Next-state logic: acceptance, load wait and timeout abandonment.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    pend_sel_d = pend_sel_q;
    pend_we_d  = pend_we_q;
    err_d      = err_q;
    case (state_q)
      IDLE, COMMIT: begin
        if (xfer_s) begin
          if (is_load_s) begin
            state_d    = WAIT_LOAD;
            pend_sel_d = in_if.in_regsel;
            pend_we_d  = in_if.in_reg_write;
            tmo_d      = '0;
          end else begin
            state_d = COMMIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (mem_rdata_valid) begin
          state_d = COMMIT;
        end else if (tmo_inc_s == TMO_W'(LOAD_TIMEOUT)) begin
          state_d = IDLE;
          tmo_d   = tmo_inc_s;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_inc_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: outputs are loaded only on entry to COMMIT, so they hold otherwise.
  always_comb begin
    if (state_q == WAIT_LOAD) begin
      commit_data_s = mem_rdata;
      commit_sel_s  = pend_sel_q;
      commit_we_s   = pend_we_q;
    end else begin
      commit_data_s = sel_data_s;
      commit_sel_s  = in_if.in_regsel;
      commit_we_s   = in_if.in_reg_write;
    end
    if (state_d == COMMIT) begin
      writedata_d   = commit_data_s;
      writeregsel_d = commit_sel_s;
      reg_write_d   = commit_we_s & (commit_sel_s != 5'd0);
      retired_d     = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      writedata_d   = writedata_q;
      writeregsel_d = writeregsel_q;
      reg_write_d   = 1'b0;
      retired_d     = retired_q;
    end
  end

  assign writedata     = writedata_q;
  assign writeregsel   = writeregsel_q;
  assign RegWrite      = reg_write_q;
  assign busy          = (state_q == WAIT_LOAD);
  assign retired_count = retired_q;
  assign err           = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: stimulus pushes expected writes into a
// queue, and a negedge monitor pops and compares on every RegWrite.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic [31:0] writedata;
  logic [4:0]  writeregsel;
  logic        RegWrite;
  logic        busy;
  logic [15:0] retired_count;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;
  logic [36:0] exp_q[$];

  writeback_stage_if #(.DATA_W(32)) bus ();

  writeback_stage #(.DATA_W(32), .CNT_W(16), .LOAD_TIMEOUT(15)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_if           (bus),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .writedata       (writedata),
    .writeregsel     (writeregsel),
    .RegWrite        (RegWrite),
    .busy            (busy),
    .retired_count   (retired_count),
    .err             (err)
  );

  always #5 clk = ~clk;

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got r%0d=0x%08h, expected no write", writeregsel, writedata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({writeregsel, writedata} !== e) begin
          failures++;
          $display("FAIL write: got r%0d=0x%08h, expected r%0d=0x%08h",
                   writeregsel, writedata, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic jal, input logic m2r, input logic rw,
                      input logic [4:0] sel, input logic [31:0] res, input logic [31:0] pc8);
    int n;
    bus.in_valid      = 1'b1;
    bus.in_is_jal     = jal;
    bus.in_mem_to_reg = m2r;
    bus.in_reg_write  = rw;
    bus.in_regsel     = sel;
    bus.in_result     = res;
    bus.in_pc_plus_8  = pc8;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("ready_timeout", {63'd0, bus.in_ready}, 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    mem_rdata = 32'd0;
    mem_rdata_valid = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_is_jal = 1'b0;
    bus.in_mem_to_reg = 1'b0;
    bus.in_reg_write = 1'b0;
    bus.in_regsel = 5'd0;
    bus.in_result = 32'd0;
    bus.in_pc_plus_8 = 32'd0;
    tick();
    tick();
    chk("rst_writedata", {32'd0, writedata}, 64'd0);
    chk("rst_regsel", {59'd0, writeregsel}, 64'd0);
    chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("rst_count", {48'd0, retired_count}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_ready", {63'd0, bus.in_ready}, 64'd1);
    rst = 1'b0;
    tick();

    // 1: plain ALU op
    exp_q.push_back({5'd5, 32'h0000_1234});
    send(1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0);
    chk("alu_regwrite", {63'd0, RegWrite}, 64'd1);
    exp_count++;
    tick();
    chk("alu_count", {48'd0, retired_count}, 64'(exp_count));

    // 2: JAL wins over mem_to_reg, never waits for load data
    exp_q.push_back({5'd31, 32'h0000_0040});
    send(1'b1, 1'b1, 1'b1, 5'd31, 32'h0000_9999, 32'h0000_0040);
    chk("jal_not_busy", {63'd0, busy}, 64'd0);
    exp_count++;
    tick();

    // 3: load; rdata_valid in the acceptance cycle must be ignored
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'h0000_DEAD;
    send(1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_1111, 32'h0);
    mem_rdata_valid = 1'b0;
    chk("load_ready_low", {63'd0, bus.in_ready}, 64'd0);
    chk("load_busy", {63'd0, busy}, 64'd1);
    chk("load_hold_sel", {59'd0, writeregsel}, 64'd31);
    tick();
    chk("load_busy2", {63'd0, busy}, 64'd1);
    tick();
    chk("load_busy3", {63'd0, busy}, 64'd1);
    exp_q.push_back({5'd9, 32'h0000_BEEF});
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'h0000_BEEF;
    tick();
    mem_rdata_valid = 1'b0;
    mem_rdata = 32'h0;
    chk("load_regwrite", {63'd0, RegWrite}, 64'd1);
    exp_count++;
    tick();
    chk("hold_data", {32'd0, writedata}, 64'h0000_BEEF);
    chk("hold_sel", {59'd0, writeregsel}, 64'd9);
    chk("hold_regwrite_low", {63'd0, RegWrite}, 64'd0);

    // 4: load timeout after 15 WAIT_LOAD cycles
    send(1'b0, 1'b1, 1'b1, 5'd12, 32'h0, 32'h0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("timeout_cycles", 64'(n), 64'd15);
    chk("timeout_err", {63'd0, err}, 64'd1);
    chk("timeout_count", {48'd0, retired_count}, 64'(exp_count));
    chk("timeout_hold_sel", {59'd0, writeregsel}, 64'd9);
    exp_q.push_back({5'd3, 32'h0000_0077});
    send(1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0077, 32'h0);
    exp_count++;
    tick();
    chk("after_timeout_count", {48'd0, retired_count}, 64'(exp_count));

    // 5: r0 write suppressed but still retired
    send(1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_00AA, 32'h0);
    chk("r0_regwrite", {63'd0, RegWrite}, 64'd0);
    exp_count++;
    tick();
    chk("r0_count", {48'd0, retired_count}, 64'(exp_count));

    // 6: four back-to-back ALU ops commit on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({5'(10 + i), 32'(32'hA0 + i)});
      send(1'b0, 1'b0, 1'b1, 5'(10 + i), 32'(32'hA0 + i), 32'h0);
      chk("b2b_regwrite", {63'd0, RegWrite}, 64'd1);
      exp_count++;
    end
    tick();
    chk("b2b_end", {63'd0, RegWrite}, 64'd0);
    chk("b2b_count", {48'd0, retired_count}, 64'(exp_count));

    // rst during a pending load discards it
    send(1'b0, 1'b1, 1'b1, 5'd20, 32'h0, 32'h0);
    chk("pend_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("prst_writedata", {32'd0, writedata}, 64'd0);
    chk("prst_regsel", {59'd0, writeregsel}, 64'd0);
    chk("prst_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("prst_busy", {63'd0, busy}, 64'd0);
    chk("prst_count", {48'd0, retired_count}, 64'd0);
    chk("prst_err", {63'd0, err}, 64'd0);
    mem_rdata_valid = 1'b1;
    mem_rdata = 32'h0000_5555;
    tick();
    tick();
    mem_rdata_valid = 1'b0;
    tick();
    chk("prst_no_write", {63'd0, RegWrite}, 64'd0);
    chk("prst_count2", {48'd0, retired_count}, 64'd0);

    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
